// File: rtl/dwpe_array_mac.sv
// Depthwise-conv PE array: accumulates K*K broadcast-weight taps over a
// POY x POX pixel tile, then rounds, clamps and emits the tile over valid/ready.

// One output lane: tap accumulator plus the post-process and result register.
module dwpe_lane #(
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          add,
    input  logic          post,
    input  logic [DW-1:0] pixel,
    input  logic [DW-1:0] weight,
    input  logic [AW-1:0] bias,
    input  logic [SW-1:0] shift,
    input  logic          relu,
    output logic [DW-1:0] result
);
    localparam logic signed [AW:0] SMAX = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] SMIN = ~SMAX;

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_x;
    logic signed [AW-1:0]   acc;
    logic signed [AW:0]     ext, rnd, shifted, clamped;

    assign prod   = $signed(pixel) * $signed(weight);
    assign prod_x = {{(AW-2*DW){prod[2*DW-1]}}, prod};

    // Tap 0 restarts the sum from bias so nothing leaks from the previous tile.
    always_ff @(posedge clk) begin
        if (!rst_n)   acc <= '0;
        else if (ld)  acc <= $signed(bias) + prod_x;
        else if (add) acc <= acc + prod_x;
    end

    // Round half up, shift, optional ReLU, saturate. One extra bit keeps the
    // rounding add from wrapping at the accumulator's top end.
    always_comb begin
        ext     = {acc[AW-1], acc};
        rnd     = ((AW+1)'(1) << shift) >> 1;
        shifted = (ext + rnd) >>> shift;
        clamped = shifted;
        if (relu && shifted < 0) clamped = '0;
        if (clamped > SMAX)      clamped = SMAX;
        else if (clamped < SMIN) clamped = SMIN;
    end

    // Result only changes in POST, so it holds steady while the tile waits in OUT.
    always_ff @(posedge clk) begin
        if (!rst_n)    result <= '0;
        else if (post) result <= clamped[DW-1:0];
    end
endmodule

module dwpe_array_mac #(
    parameter int DW  = 16,
    parameter int AW  = 40,
    parameter int POX = 16,
    parameter int POY = 3,
    parameter int K   = 3,
    parameter int SW  = 5,
    localparam int NTAP = K * K,
    localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [POY-1:0][POX-1:0][DW-1:0] pixel_array,
    input  logic [DW-1:0]                   weight,
    input  logic [AW-1:0]                   bias,
    input  logic [SW-1:0]                   cfg_shift,
    input  logic                            cfg_relu,
    output logic [TW-1:0]                   tap_idx,
    output logic [POY-1:0][POX-1:0][DW-1:0] result,
    output logic                            out_valid,
    input  logic                            out_ready
);
    typedef enum logic [1:0] {ACC, POST, OUT} state_t;

    state_t        state;
    logic [SW-1:0] shift_q;
    logic          relu_q;
    logic          hs, first, last;

    assign in_ready = (state == ACC);
    assign hs       = in_valid & in_ready;
    assign first    = hs && (tap_idx == '0);
    assign last     = (tap_idx == TW'(NTAP - 1));

    // Tile sequencing; bias goes straight into the accumulators on tap 0, so
    // only the post-process controls need holding for the rest of the tile.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            tap_idx   <= '0;
            out_valid <= 1'b0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
        end else begin
            case (state)
                ACC: if (hs) begin
                    if (first) begin
                        shift_q <= cfg_shift;
                        relu_q  <= cfg_relu;
                    end
                    if (last) begin
                        tap_idx <= '0;
                        state   <= POST;
                    end else begin
                        tap_idx <= tap_idx + TW'(1);
                    end
                end
                POST: begin
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

    for (genvar y = 0; y < POY; y++) begin : g_row
        for (genvar x = 0; x < POX; x++) begin : g_col
            dwpe_lane #(.DW(DW), .AW(AW), .SW(SW)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .ld     (first),
                .add    (hs),
                .post   (state == POST),
                .pixel  (pixel_array[y][x]),
                .weight (weight),
                .bias   (bias),
                .shift  (shift_q),
                .relu   (relu_q),
                .result (result[y][x])
            );
        end
    end
endmodule

// File: tb/tb_dwpe_array_mac.sv
// Scoreboard bench for dwpe_array_mac: stimulus pushes expected tiles,
// a negedge monitor pops and compares on every output handshake.
module tb_dwpe_array_mac;
    localparam int DW = 16, AW = 40, POX = 16, POY = 3, K = 3, SW = 5;
    localparam int NTAP = K * K, TW = 4;
    typedef logic [POY-1:0][POX-1:0][DW-1:0] tile_t;

    logic          clk = 0, rst_n = 0, in_valid = 0, in_ready, cfg_relu = 0;
    logic          out_valid, out_ready = 1;
    tile_t         pixel_array = '0, result;
    logic [DW-1:0] weight = '0;
    logic [AW-1:0] bias = '0;
    logic [SW-1:0] cfg_shift = '0;
    logic [TW-1:0] tap_idx;

    tile_t exp_q[$];
    tile_t mon_e;
    int    errors = 0, checks = 0;

    dwpe_array_mac #(.DW(DW), .AW(AW), .POX(POX), .POY(POY), .K(K), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_array(pixel_array), .weight(weight), .bias(bias), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .tap_idx(tap_idx), .result(result), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic tile_t fill(input int v);
        tile_t t;
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) t[y][x] = DW'(v);
        return t;
    endfunction

    // Independent reference: floor division instead of a shift.
    function automatic int model_post(input longint a, input int sh, input bit rl);
        longint num, d, q;
        if (sh == 0) q = a;
        else begin
            d   = longint'(1) << sh;
            num = a + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
        end
        if (rl && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tile(input string name, input tile_t act, input tile_t exp);
        bit bad = 0;
        checks++;
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
                if (!bad && act[y][x] !== exp[y][x]) begin
                    bad = 1;
                    errors++;
                    $display("FAIL %s: lane[%0d][%0d] got %0d expected %0d", name, y, x,
                             $signed(act[y][x]), $signed(exp[y][x]));
                end
    endtask

    // Monitor: every output handshake must match the oldest expected tile.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tile: got a tile, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                chk_tile("tile", result, mon_e);
            end
        end
    end

    // Offer one beat until accepted; exp_tap >= 0 also checks the fetch index.
    task automatic beat(input tile_t px, input int w, input longint b, input int sh,
                        input bit rl, input int exp_tap);
        int g = 0;
        bit ok = 0;
        while (!ok && g < 50) begin
            @(negedge clk);
            pixel_array = px; weight = DW'(w); bias = AW'(b);
            cfg_shift = SW'(sh); cfg_relu = rl; in_valid = 1;
            if (in_ready) begin
                ok = 1;
                if (exp_tap >= 0) check("tap_idx", tap_idx, exp_tap);
            end
            @(posedge clk);
            g++;
        end
        #1 in_valid = 0;
        if (!ok) check("beat_timeout", 0, 1);
    endtask

    task automatic run_tile(input int pix, input int w, input longint b, input int sh,
                            input bit rl, input int exp);
        exp_q.push_back(fill(exp));
        for (int i = 0; i < NTAP; i++) beat(fill(pix), w, b, sh, rl, i);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    tile_t  px5[NTAP];
    int     w5[NTAP];
    tile_t  e5;
    longint acc5;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_tap_idx", tap_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        chk_tile("rst_result", result, fill(0));

        // 1: all ones, back to back, with latency and tap wrap
        run_tile(1, 1, 0, 0, 0, 9);
        @(negedge clk);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 0);
        check("wrap_tap_idx", tap_idx, 0);
        @(negedge clk);
        check("lat_out_valid", out_valid, 1);
        drain();

        // 2: saturation and rounding
        run_tile(100, 100, 0, 0, 0, 32767);
        run_tile(-100, 100, 0, 0, 0, -32768);
        run_tile(100, 100, 0, 4, 0, 5625);
        run_tile(0, 0, 3, 1, 0, 2);
        run_tile(0, 0, -3, 1, 0, -1);
        drain();

        // 3: negative sums and ReLU
        run_tile(-5, 3, 0, 0, 0, -135);
        run_tile(-5, 3, 0, 0, 1, 0);
        run_tile(-5, 3, 200, 0, 1, 65);
        drain();

        // 4: backpressure in OUT
        out_ready = 0;
        run_tile(2, 3, 0, 0, 0, 54);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            pixel_array = fill(7); weight = 16'd7; in_valid = 1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            chk_tile("bp_result", result, fill(54));
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 0; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("bp_back_in_ready", in_ready, 1);
        check("bp_back_out_valid", out_valid, 0);
        check("bp_tap_idx", tap_idx, 0);
        drain();

        // 5: mixed signed data with random gaps
        acc5 = 0;
        for (int i = 0; i < NTAP; i++) begin
            w5[i] = int'($urandom_range(0, 200)) - 100;
            for (int y = 0; y < POY; y++)
                for (int x = 0; x < POX; x++)
                    px5[i][y][x] = DW'(int'($urandom_range(0, 400)) - 200);
        end
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) begin
                acc5 = 1234;
                for (int i = 0; i < NTAP; i++)
                    acc5 += longint'($signed(px5[i][y][x])) * w5[i];
                e5[y][x] = DW'(model_post(acc5, 3, 0));
            end
        exp_q.push_back(e5);
        for (int i = 0; i < NTAP; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                in_valid = 0;
                check("gap_tap_idx", tap_idx, i);
            end
            beat(px5[i], w5[i], (i == 0) ? 1234 : -777, (i == 0) ? 3 : 0, 1'b0, i);
        end
        drain();

        // 6: reset mid-tile, then a clean tile ignoring late cfg changes
        for (int i = 0; i < 4; i++) beat(fill(50), 50, 999, 0, 0, i);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("mid_rst_tap_idx", tap_idx, 0);
        check("mid_rst_out_valid", out_valid, 0);
        chk_tile("mid_rst_result", result, fill(0));
        exp_q.push_back(fill(-8));
        beat(fill(2), -1, 10, 0, 0, 0);
        for (int i = 1; i < NTAP; i++) beat(fill(2), -1, 1000, 3, 1, i);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
